note_sequencer: RTL

//  Step sequencer in front of the synth voice. Stores a short pattern of oscillator counts.

---
 rtl/note_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/note_sequencer.sv
// Pattern step sequencer between the SPI register block and osc/adsr.
// SEQ_LOOP_EN: loop the pattern while run is high (else one-shot).
module note_sequencer #(
  parameter  int STEPS  = 8,
  parameter  int TICK_W = 16,
  localparam int AW     = $clog2(STEPS)
) (
  input  logic              clk,
  input  logic              arstn,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [12:0]       wr_data,
  input  logic [AW-1:0]     seq_len,
  input  logic [TICK_W-1:0] tempo_div,
  input  logic [TICK_W-1:0] gate_len,
  input  logic              run,
  input  logic [11:0]       spi_osc_count,
  input  logic              spi_trig,
  output logic [11:0]       osc_count,
  output logic              trig,
  output logic [AW-1:0]     step,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GATE_ON  = 2'd1,
    GATE_OFF = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     step_q, step_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [11:0]       hold_q, hold_d;
  logic              rest_q, rest_d;
  logic              done_q, done_d;
  logic [12:0]       mem_q [STEPS];
  logic [12:0]       mem_d [STEPS];

  logic [TICK_W-1:0] t_eff, t_m1, g_eff, g_m1;
  logic              last, over, load;
  logic [AW-1:0]     nxt_step, ld_idx;
  logic [12:0]       entry;

  // Effective step period and gate length; gate always leaves one low cycle
  always_comb begin
    t_eff = (tempo_div < TICK_W'(2)) ? TICK_W'(2) : tempo_div;
    t_m1  = t_eff - TICK_W'(1);
    if (gate_len == '0)
      g_eff = TICK_W'(1);
    else if (gate_len > t_m1)
      g_eff = t_m1;
    else
      g_eff = gate_len;
    g_m1     = g_eff - TICK_W'(1);
    last     = (step_q == seq_len);
    over     = (step_q > seq_len);
    nxt_step = (last || over) ? '0 : step_q + AW'(1);
  end

  // Next-state logic: pattern writes, tick/step counting, entry loading
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    tick_d  = tick_q;
    hold_d  = hold_q;
    rest_d  = rest_q;
    done_d  = done_q;
    load    = 1'b0;
    ld_idx  = '0;
    entry   = '0;
    mem_d   = mem_q;
    if (wr_en)
      mem_d[wr_addr] = wr_data;
    if (!run) begin
      state_d = IDLE;
      step_d  = '0;
      tick_d  = '0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!done_q) begin
            state_d = GATE_ON;
            step_d  = '0;
            tick_d  = '0;
            load    = 1'b1;
            ld_idx  = '0;
          end
        end
        GATE_ON, GATE_OFF: begin
          if (tick_q >= t_m1) begin
            tick_d = '0;
`ifndef SEQ_LOOP_EN
            if (last) begin
              state_d = IDLE;
              step_d  = '0;
              done_d  = 1'b1;
            end else begin
`else
            begin
`endif
              state_d = GATE_ON;
              step_d  = nxt_step;
              load    = 1'b1;
              ld_idx  = nxt_step;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
            if (state_q == GATE_ON && tick_q >= g_m1)
              state_d = GATE_OFF;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (load) begin
      entry  = mem_q[ld_idx];
      rest_d = entry[12];
      if (!entry[12])
        hold_d = entry[11:0];
    end
  end

  // State, counters, hold register and pattern storage
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= IDLE;
      step_q  <= '0;
      tick_q  <= '0;
      hold_q  <= '0;
      rest_q  <= 1'b1;
      done_q  <= 1'b0;
      for (int i = 0; i < STEPS; i++)
        mem_q[i] <= 13'h1000;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      tick_q  <= tick_d;
      hold_q  <= hold_d;
      rest_q  <= rest_d;
      done_q  <= done_d;
      mem_q   <= mem_d;
    end
  end

  // Output mux: sequencer values while busy, SPI passthrough otherwise
  always_comb begin
    busy      = (state_q != IDLE);
    step      = step_q;
    osc_count = busy ? hold_q : spi_osc_count;
    trig      = busy ? (state_q == GATE_ON && !rest_q) : spi_trig;
  end

endmodule
